core_sqrt_nr: RTL and testbench

Parametrised iterative square-root / inverse-square-root mantissa core for the LAMP FPU. It is the successor of the fixed 9-bit core, with generic mantissa width, iteration count and guard bits, a ready/valid handshake, synchronous flush and a registered, held result. It sits under the floating-point SQRT top level, which prepares the pre-shifted mantissa and normalises and rounds the result.

---
 rtl/lampFPU_pkg.sv | 17 +
 rtl/sqrt_nr_step.sv | 31 +++
 rtl/core_sqrt_nr.sv | 142 ++++++++++++++
 tb/tb_core_sqrt_nr.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/lampFPU_pkg.sv
// Shared definitions for the LAMP FPU square-root datapath: default mantissa
// width, the iterative core state encoding and the 1.5 constant generator.
package lampFPU_pkg;

    localparam int LAMP_FLOAT_F_DW = 7;

    typedef enum logic {
        IDLE    = 1'b0,
        COMPUTE = 1'b1
    } sqrtState_t;

    // 1.5 in Q1.(w-1): the two MSBs set, the rest zero. Valid for 2 <= w <= 32.
    function automatic logic [31:0] sqrt_three_halves(input int unsigned w);
        return 32'd3 << (w - 2);
    endfunction

endpackage

// File: rtl/sqrt_nr_step.sv
// One combinational Goldschmidt iteration on Q1.(WI-1) operands:
//   b'  = trunc(b*y*y), y' = 1.5 - b'/2, res' = trunc(res*y').
// The full res*y' product is exported so the final iteration can keep more
// result bits than the WI-bit working width.
module sqrt_nr_step
    import lampFPU_pkg::*;
#(
    parameter int WI = 9
) (
    input  logic [WI-1:0]   b,
    input  logic [WI-1:0]   y,
    input  logic [WI-1:0]   res,
    output logic [WI-1:0]   b_nxt,
    output logic [WI-1:0]   y_nxt,
    output logic [WI-1:0]   res_nxt,
    output logic [2*WI-1:0] p_full
);

    localparam logic [WI-1:0] THREE_HALVES = WI'(sqrt_three_halves(WI));

    logic [3*WI-1:0] byy;

    // b*y*y is formed at full precision and truncated once; the integer bits
    // above the single kept one are zero for in-range operands.
    assign byy     = (3*WI)'(b) * (3*WI)'(y) * (3*WI)'(y);
    assign b_nxt   = WI'(byy >> (2*(WI-1)));
    assign y_nxt   = THREE_HALVES - (b_nxt >> 1);
    assign p_full  = (2*WI)'(res) * (2*WI)'(y_nxt);
    assign res_nxt = WI'(p_full >> (WI-1));

endmodule

// File: rtl/core_sqrt_nr.sv
// Iterative square-root / inverse-square-root mantissa core.
// Takes a pre-shifted Q1.(F_DW+1) mantissa in [0.5, 2) and returns a
// Q1.(2*F_DW+1) result after ITER Goldschmidt iterations. The result is held
// until the next completion; valid_o pulses for one cycle.
// Optional build macro: LAMP_SQRT_EARLY_EXIT_EN ends the computation as soon
// as the correction factor y' reaches exactly 1.0.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | ready_o=1, waits for doSqrt_i / doInvSqrt_i
//   COMPUTE | one iteration per cycle, ends on last iteration or flush_i
module core_sqrt_nr
    import lampFPU_pkg::*;
#(
    parameter int F_DW  = LAMP_FLOAT_F_DW,
    parameter int ITER  = 5,
    parameter int GUARD = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  doSqrt_i,
    input  logic                  doInvSqrt_i,
    input  logic                  flush_i,
    input  logic [F_DW+1:0]       f_i,
    output logic                  ready_o,
    output logic                  valid_o,
    output logic                  isSqrt_o,
    output logic [2*(F_DW+1)-1:0] result_o
);

    localparam int WI = F_DW + 2 + GUARD;
    localparam int RW = 2 * (F_DW + 1);

    localparam logic [WI-1:0] THREE_HALVES = WI'(sqrt_three_halves(WI));
    localparam logic [3:0]    CNT_LAST     = 4'(ITER - 1);

    sqrtState_t      state;
    logic [WI-1:0]   b_q;
    logic [WI-1:0]   y_q;
    logic [WI-1:0]   res_q;
    logic [3:0]      cnt_q;
    logic            op_sqrt_q;

    logic [WI-1:0]   b_ld;
    logic [WI-1:0]   y_ld;
    logic [2*WI-1:0] p_ld;
    logic [WI-1:0]   res_sqrt_ld;

    logic [WI-1:0]   b_nxt;
    logic [WI-1:0]   y_nxt;
    logic [WI-1:0]   res_nxt;
    logic [2*WI-1:0] p_full;
    logic [RW-1:0]   result_nxt;
    logic            last_iter;
    logic            req;

    // Seed values for an accepted request: b is f_i with GUARD zero LSBs,
    // y0 = 1.5 - b/2, and the sqrt path starts from b*y0 rather than y0.
    assign b_ld        = WI'(f_i) << GUARD;
    assign y_ld        = THREE_HALVES - (b_ld >> 1);
    assign p_ld        = (2*WI)'(b_ld) * (2*WI)'(y_ld);
    assign res_sqrt_ld = WI'(p_ld >> (WI-1));

    assign req = doSqrt_i | doInvSqrt_i;

    sqrt_nr_step #(
        .WI (WI)
    ) u_step (
        .b       (b_q),
        .y       (y_q),
        .res     (res_q),
        .b_nxt   (b_nxt),
        .y_nxt   (y_nxt),
        .res_nxt (res_nxt),
        .p_full  (p_full)
    );

    // Result keeps one integer bit and 2*F_DW+1 fraction bits of res*y'.
    assign result_nxt = RW'(p_full >> (2*WI-1-RW));

`ifdef LAMP_SQRT_EARLY_EXIT_EN
    localparam logic [WI-1:0] ONE = WI'(1) << (WI-1);
    assign last_iter = (cnt_q == CNT_LAST) || (y_nxt == ONE);
`else
    assign last_iter = (cnt_q == CNT_LAST);
`endif

    // Control FSM, iteration registers and held output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ready_o   <= 1'b1;
            valid_o   <= 1'b0;
            isSqrt_o  <= 1'b0;
            result_o  <= '0;
            b_q       <= '0;
            y_q       <= '0;
            res_q     <= '0;
            cnt_q     <= '0;
            op_sqrt_q <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    // flush_i blocks acceptance in the same cycle
                    if (req && !flush_i) begin
                        b_q       <= b_ld;
                        y_q       <= y_ld;
                        res_q     <= doSqrt_i ? res_sqrt_ld : y_ld;
                        op_sqrt_q <= doSqrt_i;
                        cnt_q     <= '0;
                        state     <= COMPUTE;
                        ready_o   <= 1'b0;
                    end
                end
                COMPUTE: begin
                    if (flush_i) begin
                        state   <= IDLE;
                        ready_o <= 1'b1;
                    end else begin
                        b_q   <= b_nxt;
                        y_q   <= y_nxt;
                        res_q <= res_nxt;
                        cnt_q <= cnt_q + 4'd1;
                        if (last_iter) begin
                            result_o <= result_nxt;
                            isSqrt_o <= op_sqrt_q;
                            valid_o  <= 1'b1;
                            state    <= IDLE;
                            ready_o  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_sqrt_nr.sv
// Directed bench for core_sqrt_nr with F_DW=7, ITER=5, GUARD=0.
module tb_core_sqrt_nr;

    logic        clk = 1'b0;
    logic        rst;
    logic        doSqrt_i;
    logic        doInvSqrt_i;
    logic        flush_i;
    logic [8:0]  f_i;
    logic        ready_o;
    logic        valid_o;
    logic        isSqrt_o;
    logic [15:0] result_o;

    int checks = 0;
    int errors = 0;

`ifdef LAMP_SQRT_EARLY_EXIT_EN
    localparam int LAT1 = 2;
    localparam bit EE   = 1'b1;
`else
    localparam int LAT1 = 6;
    localparam bit EE   = 1'b0;
`endif

    core_sqrt_nr #(
        .F_DW  (7),
        .ITER  (5),
        .GUARD (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .doSqrt_i    (doSqrt_i),
        .doInvSqrt_i (doInvSqrt_i),
        .flush_i     (flush_i),
        .f_i         (f_i),
        .ready_o     (ready_o),
        .valid_o     (valid_o),
        .isSqrt_o    (isSqrt_o),
        .result_o    (result_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sq;
        logic        inv;
        logic [8:0]  f;
        logic [15:0] exp_res;
        int          tol;
        logic        exp_is;
        int          lat_ee;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_near(input string name, input logic [15:0] act, input logic [15:0] exp, input int tol);
        int d;
        checks++;
        d = int'(act) - int'(exp);
        if (d < 0) d = -d;
        if (d > tol) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h +/- %0d", name, act, exp, tol);
        end
    endtask

    task automatic run_op(input logic sq, input logic inv, input logic [8:0] f,
                          output int lat, output logic [15:0] res, output logic is_sq);
        doSqrt_i    = sq;
        doInvSqrt_i = inv;
        f_i         = f;
        lat         = -1;
        res         = '0;
        is_sq       = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            doSqrt_i    = 1'b0;
            doInvSqrt_i = 1'b0;
            if (i == 1) check("busy_after_accept", 32'(ready_o), 32'd0);
            if (valid_o) begin
                lat   = i;
                res   = result_o;
                is_sq = isSqrt_o;
                break;
            end
        end
    endtask

    initial begin
        int          lat;
        logic [15:0] res;
        logic        is_sq;
        int          t1, t2, nvalid;

        // Expected values: 1.0 -> exactly 1.0 (0x8000); 0.5 -> sqrt 0x5A82 /
        // rsqrt 0xB505; 0.75 -> sqrt 0x6EDA / rsqrt 0x93CD, all within 2^-7.
        vecs[0] = '{1'b1, 1'b0, 9'h100, 16'h8000, 0,   1'b1, 2};
        vecs[1] = '{1'b0, 1'b1, 9'h100, 16'h8000, 0,   1'b0, 2};
        vecs[2] = '{1'b0, 1'b1, 9'h080, 16'hB505, 256, 1'b0, 5};
        vecs[3] = '{1'b1, 1'b0, 9'h080, 16'h5A82, 256, 1'b1, 5};
        vecs[4] = '{1'b1, 1'b1, 9'h100, 16'h8000, 0,   1'b1, 2};
        vecs[5] = '{1'b1, 1'b0, 9'h0C0, 16'h6EDA, 256, 1'b1, 3};
        vecs[6] = '{1'b0, 1'b1, 9'h0C0, 16'h93CD, 256, 1'b0, 3};

        rst = 1'b1; doSqrt_i = 1'b0; doInvSqrt_i = 1'b0; flush_i = 1'b0; f_i = '0;
        #12;
        check("reset_ready",  32'(ready_o),  32'd1);
        check("reset_valid",  32'(valid_o),  32'd0);
        check("reset_issqrt", 32'(isSqrt_o), 32'd0);
        check("reset_result", 32'(result_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        for (int k = 0; k < 7; k++) begin
            run_op(vecs[k].sq, vecs[k].inv, vecs[k].f, lat, res, is_sq);
            check($sformatf("latency_%0d", k), 32'(lat), 32'(EE ? vecs[k].lat_ee : 6));
            check_near($sformatf("result_%0d", k), res, vecs[k].exp_res, vecs[k].tol);
            check($sformatf("issqrt_%0d", k), 32'(is_sq), 32'(vecs[k].exp_is));
            check($sformatf("ready_at_valid_%0d", k), 32'(ready_o), 32'd1);
            tick();
        end

        // Back-to-back: sqrt request held through COMPUTE, inverse sqrt in the valid cycle.
        t1 = -1; t2 = -1; nvalid = 0;
        doSqrt_i = 1'b1; f_i = 9'h100;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (valid_o) begin
                nvalid++;
                if (t1 < 0) begin
                    t1 = i;
                    doSqrt_i = 1'b0;
                    doInvSqrt_i = 1'b1;
                end else begin
                    if (t2 < 0) begin
                        t2 = i;
                        check("b2b_issqrt", 32'(isSqrt_o), 32'd0);
                        check("b2b_result", 32'(result_o), 32'h8000);
                    end
                    doSqrt_i = 1'b0;
                    doInvSqrt_i = 1'b0;
                end
            end else if (t1 >= 0) begin
                doInvSqrt_i = 1'b0;
                doSqrt_i = (t2 < 0) && (i < t1 + LAT1 - 1);
            end
        end
        doSqrt_i = 1'b0; doInvSqrt_i = 1'b0;
        check("b2b_first_latency", 32'(t1), 32'(LAT1));
        check("b2b_spacing", 32'(t2 - t1), 32'(LAT1));
        check("b2b_valid_count", 32'(nvalid), 32'd2);

        // Flush in cycle 3 of an inverse sqrt of 0.5.
        doInvSqrt_i = 1'b1; f_i = 9'h080;
        tick();
        doInvSqrt_i = 1'b0;
        tick();
        tick();
        check("flush_busy_c3", 32'(ready_o), 32'd0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("flush_ready_c4", 32'(ready_o), 32'd1);
        check("flush_no_valid", 32'(valid_o), 32'd0);
        check("flush_result_held", 32'(result_o), 32'h8000);
        nvalid = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (valid_o) nvalid++;
        end
        check("flush_no_late_valid", 32'(nvalid), 32'd0);

        // Asynchronous reset mid-COMPUTE after a completed sqrt.
        run_op(1'b1, 1'b0, 9'h100, lat, res, is_sq);
        check("pre_rst_result", 32'(res), 32'h8000);
        check("pre_rst_issqrt", 32'(is_sq), 32'd1);
        tick();
        doSqrt_i = 1'b1; f_i = 9'h080;
        tick();
        doSqrt_i = 1'b0;
        tick();
        check("pre_rst_busy", 32'(ready_o), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("rst_ready",  32'(ready_o),  32'd1);
        check("rst_valid",  32'(valid_o),  32'd0);
        check("rst_issqrt", 32'(isSqrt_o), 32'd0);
        check("rst_result", 32'(result_o), 32'd0);
        #1 rst = 1'b0;
        nvalid = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (valid_o) nvalid++;
        end
        check("rst_no_valid", 32'(nvalid), 32'd0);
        check("rst_idle_after", 32'(ready_o), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
